// File: rtl/fir_seq_pkg.sv
// Shared defaults, data types and output-FSM encoding for the L=3 parallel FIR block sequencer.
package fir_seq_pkg;

  localparam int DW_DEF = 32;
  localparam int YW_DEF = 64;
  localparam int L_DEF  = 3;

  typedef logic signed [DW_DEF-1:0]       sample_t;
  typedef logic signed [YW_DEF-1:0]       ysample_t;
  typedef logic [L_DEF*DW_DEF-1:0]        block_x_t;
  typedef logic [L_DEF*YW_DEF-1:0]        block_y_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } out_state_e;

endpackage

// File: rtl/fir_seq_obuf.sv
// Synchronous block FIFO for datapath results; exposes the head block, the block behind it and the fill count.
module fir_seq_obuf
  import fir_seq_pkg::*;
#(
  parameter int W     = L_DEF * YW_DEF,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [W-1:0]                 wr_data,
  input  logic                         rd_en,
  output logic [W-1:0]                 rd_data,
  output logic [W-1:0]                 rd_data_next,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          wr_ok_s;
  logic          rd_ok_s;

  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign wr_ok_s = wr_en && ((count_r != CW'(DEPTH)) || rd_en);
  assign rd_ok_s = rd_en && (count_r != {CW{1'b0}});

  // Block storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(wr_ok_s) - CW'(rd_ok_s);
    end
  end

  assign rd_data      = mem_r[rd_ptr_r];
  assign rd_data_next = mem_r[rd_ptr_r + AW'(1)];
  assign count        = count_r;

endmodule

// File: rtl/fir_block_sequencer.sv
// Packs a serial sample stream into L-sample blocks for the parallel FIR and re-serialises its block results.
// Optional zero-pad flush of a partial block is enabled by defining FIR_SEQ_FLUSH_EN.
module fir_block_sequencer
  import fir_seq_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int YW         = YW_DEF,
  parameter int L          = L_DEF,
  parameter int FILT_LAT   = 1,
  parameter int OBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef FIR_SEQ_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  output logic              fx_adv,
  output logic [L*DW-1:0]   fx_x,
  input  logic [L*YW-1:0]   fy_y,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [YW-1:0]     m_data,
  output logic              busy
);

  localparam int PW = (L > 1) ? $clog2(L) : 1;
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam int FW = $clog2(FILT_LAT + 2);
  localparam int SW = ((CW > FW) ? CW : FW) + 1;
  localparam logic [PW-1:0] LAST = PW'(L - 1);

  logic [PW-1:0]       phase_r;
  logic [PW-1:0]       phase_nxt_s;
  logic [DW-1:0]       slot_r [L];
  logic                s_ready_r;
  logic                fx_adv_r;
  logic [L*DW-1:0]     fx_x_r;
  logic [L*DW-1:0]     blk_s;
  logic [FILT_LAT-1:0] adv_pipe_r;
  logic [FW-1:0]       inflight_r;
  logic [FW-1:0]       inflight_nxt_s;
  logic [CW-1:0]       obuf_count_s;
  logic [CW-1:0]       count_nxt_s;
  logic [L*YW-1:0]     head_s;
  logic [L*YW-1:0]     head_next_s;
  logic [L*YW-1:0]     src_blk_s;
  logic [PW-1:0]       slice_r;
  logic [PW-1:0]       nslice_s;
  logic [YW-1:0]       m_data_r;
  logic                m_valid_r;
  logic                busy_r;
  out_state_e          state_r;
  logic                accept_s;
  logic                issue_s;
  logic                flush_req_s;
  logic                flush_issue_s;
  logic                credit_s;
  logic                credit_nxt_s;
  logic                wr_en_s;
  logic                hs_s;
  logic                pop_s;

`ifdef FIR_SEQ_FLUSH_EN
  assign flush_req_s = flush && (phase_r != {PW{1'b0}});
`else
  assign flush_req_s = 1'b0;
`endif

  // A block may only be issued if its result is guaranteed a slot in the output buffer.
  assign credit_s      = (SW'(obuf_count_s) + SW'(inflight_r)) < SW'(OBUF_DEPTH);
  assign s_ready       = s_ready_r && !flush_req_s;
  assign accept_s      = s_valid && s_ready;
  assign flush_issue_s = flush_req_s && credit_s;
  assign issue_s       = (accept_s && (phase_r == LAST)) || flush_issue_s;
  assign wr_en_s       = adv_pipe_r[FILT_LAT-1];
  assign hs_s          = m_valid_r && m_ready;
  assign pop_s         = hs_s && (slice_r == LAST);

  // Block assembly and next-state lookahead feeding the registered ready/busy flags.
  always_comb begin
    blk_s = {(L*DW){1'b0}};
    for (int k = 0; k < L; k++) begin
      if (accept_s && (phase_r == PW'(k))) begin
        blk_s[k*DW +: DW] = s_data;
      end else if (PW'(k) < phase_r) begin
        blk_s[k*DW +: DW] = slot_r[k];
      end else begin
        blk_s[k*DW +: DW] = {DW{1'b0}};
      end
    end
    if (flush_issue_s) begin
      phase_nxt_s = {PW{1'b0}};
    end else if (accept_s) begin
      phase_nxt_s = (phase_r == LAST) ? {PW{1'b0}} : phase_r + PW'(1);
    end else begin
      phase_nxt_s = phase_r;
    end
    inflight_nxt_s = inflight_r + FW'(issue_s) - FW'(wr_en_s);
    count_nxt_s    = obuf_count_s + CW'(wr_en_s) - CW'(pop_s);
    credit_nxt_s   = (SW'(count_nxt_s) + SW'(inflight_nxt_s)) < SW'(OBUF_DEPTH);
  end

  // Input side: gather slots, issue blocks, track in-flight results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_r    <= {PW{1'b0}};
      s_ready_r  <= 1'b0;
      fx_adv_r   <= 1'b0;
      fx_x_r     <= {(L*DW){1'b0}};
      adv_pipe_r <= {FILT_LAT{1'b0}};
      inflight_r <= {FW{1'b0}};
      busy_r     <= 1'b0;
      for (int k = 0; k < L; k++) begin
        slot_r[k] <= {DW{1'b0}};
      end
    end else begin
      phase_r <= phase_nxt_s;
      if (accept_s) begin
        slot_r[phase_r] <= s_data;
      end
      s_ready_r  <= !((phase_nxt_s == LAST) && !credit_nxt_s);
      fx_adv_r   <= issue_s;
      if (issue_s) begin
        fx_x_r <= blk_s;
      end
      adv_pipe_r[0] <= fx_adv_r;
      for (int i = 1; i < FILT_LAT; i++) begin
        adv_pipe_r[i] <= adv_pipe_r[i-1];
      end
      inflight_r <= inflight_nxt_s;
      busy_r     <= (phase_nxt_s != {PW{1'b0}}) || (inflight_nxt_s != {FW{1'b0}}) ||
                    (count_nxt_s != {CW{1'b0}});
    end
  end

  fir_seq_obuf #(
    .W     (L * YW),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en_s),
    .wr_data      (fy_y),
    .rd_en        (pop_s),
    .rd_data      (head_s),
    .rd_data_next (head_next_s),
    .count        (obuf_count_s)
  );

  // Pick the block and slice that m_data presents next; a block landing in an empty buffer bypasses it.
  always_comb begin
    src_blk_s = head_s;
    nslice_s  = slice_r;
    if (state_r == ST_IDLE) begin
      src_blk_s = fy_y;
      nslice_s  = {PW{1'b0}};
    end else if (hs_s && (slice_r != LAST)) begin
      src_blk_s = head_s;
      nslice_s  = slice_r + PW'(1);
    end else if (pop_s && (obuf_count_s > CW'(1))) begin
      src_blk_s = head_next_s;
      nslice_s  = {PW{1'b0}};
    end else begin
      src_blk_s = fy_y;
      nslice_s  = {PW{1'b0}};
    end
  end

  // Output FSM: holds m_valid/m_data steady until each slice is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      m_valid_r <= 1'b0;
      m_data_r  <= {YW{1'b0}};
      slice_r   <= {PW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wr_en_s) begin
            state_r   <= ST_EMIT;
            m_valid_r <= 1'b1;
            m_data_r  <= src_blk_s[YW*int'(nslice_s) +: YW];
            slice_r   <= nslice_s;
          end else begin
            m_valid_r <= 1'b0;
          end
        end
        ST_EMIT: begin
          if (hs_s) begin
            if (pop_s && (obuf_count_s <= CW'(1)) && !wr_en_s) begin
              state_r   <= ST_IDLE;
              m_valid_r <= 1'b0;
              slice_r   <= {PW{1'b0}};
            end else begin
              m_data_r <= src_blk_s[YW*int'(nslice_s) +: YW];
              slice_r  <= nslice_s;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          m_valid_r <= 1'b0;
          slice_r   <= {PW{1'b0}};
        end
      endcase
    end
  end

  assign fx_adv  = fx_adv_r;
  assign fx_x    = fx_x_r;
  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_fir_block_sequencer.sv
// Directed bench for fir_block_sequencer with a behavioural pass-through datapath and an output scoreboard.
module tb_fir_block_sequencer;
  import fir_seq_pkg::*;

  localparam int DW = 32;
  localparam int YW = 64;
  localparam int L = 3;
  localparam int FILT_LAT = 1;
  localparam int OBUF_DEPTH = 4;
  localparam int BW = L * YW;

  logic clk = 1'b0;
  logic rst_n;
  logic s_valid;
  logic s_ready;
  logic [DW-1:0] s_data;
  logic fx_adv;
  logic [L*DW-1:0] fx_x;
  logic [L*YW-1:0] fy_y = '0;
  logic m_valid;
  logic m_ready;
  logic [YW-1:0] m_data;
  logic busy;
`ifdef FIR_SEQ_FLUSH_EN
  logic flush;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_adv = 0;
  int n_out = 0;
  int tb_phase = 0;
  int t3 = -1;
  int first_mv = -1;
  logic [YW-1:0] exp_q[$];
  logic prev_stall = 1'b0;
  logic [YW-1:0] prev_data = '0;

  always #5 clk = ~clk;

  fir_block_sequencer #(
    .DW(DW), .YW(YW), .L(L), .FILT_LAT(FILT_LAT), .OBUF_DEPTH(OBUF_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef FIR_SEQ_FLUSH_EN
    .flush(flush),
`endif
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .fx_adv(fx_adv),
    .fx_x(fx_x),
    .fy_y(fy_y),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .busy(busy)
  );

  function automatic logic [YW-1:0] sext(input logic [DW-1:0] d);
    return {{(YW-DW){d[DW-1]}}, d};
  endfunction

  // Datapath stand-in: y = x sign-extended, one cycle after fx_adv.
  always @(posedge clk) begin
    if (fx_adv) begin
      for (int k = 0; k < L; k++) fy_y[k*YW +: YW] <= sext(fx_x[k*DW +: DW]);
    end
  end

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [YW-1:0] e;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_valid", BW'(m_valid), BW'(1'b1));
        check("stall_data", BW'(m_data), BW'(prev_data));
      end
      if (fx_adv) begin
        n_adv++;
        if (tb_phase != 0) begin
          for (int k = tb_phase; k < L; k++) exp_q.push_back('0);
          tb_phase = 0;
        end
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(sext(s_data));
        n_acc++;
        tb_phase = (tb_phase + 1) % L;
        if (tb_phase == 0 && t3 < 0) t3 = cyc;
      end
      if (m_valid && first_mv < 0) first_mv = cyc;
      if (m_valid && m_ready) begin
        n_out++;
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check("out_data", BW'(m_data), BW'(e));
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    s_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == tb_phase && !m_valid) break;
      tick();
    end
    check("drain_mvalid", BW'(m_valid), BW'(1'b0));
    check("drain_queue", BW'(exp_q.size()), BW'(tb_phase));
  endtask

  initial begin
    int a0;
    int d0;
    int o0;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
`ifdef FIR_SEQ_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", BW'(s_ready), BW'(1'b0));
    check("rst_fx_adv", BW'(fx_adv), BW'(1'b0));
    check("rst_fx_x", BW'(fx_x), BW'(0));
    check("rst_m_valid", BW'(m_valid), BW'(1'b0));
    check("rst_m_data", BW'(m_data), BW'(0));
    check("rst_busy", BW'(busy), BW'(1'b0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_ready", BW'(s_ready), BW'(1'b1));

    // Ramp 1..9 with a free-running sink.
    m_ready = 1'b1;
    a0 = n_acc; d0 = n_adv; o0 = n_out;
    for (int i = 1; i <= 9; i++) begin
      s_valid = 1'b1;
      s_data = DW'(i);
      tick();
    end
    s_valid = 1'b0;
    check("ramp_accepts", BW'(n_acc - a0), BW'(9));
    drain();
    check("ramp_latency", BW'(first_mv - t3), BW'(2 + FILT_LAT));
    check("ramp_adv", BW'(n_adv - d0), BW'(3));
    check("ramp_outputs", BW'(n_out - o0), BW'(9));
    check("ramp_busy", BW'(busy), BW'(1'b0));

    // Blocked sink: credits cap acceptance.
    m_ready = 1'b0;
    a0 = n_acc; d0 = n_adv;
    for (int i = 0; i < 30; i++) begin
      s_valid = 1'b1;
      s_data = DW'(100 + i);
      tick();
    end
    check("full_accepts", BW'(n_acc - a0), BW'(OBUF_DEPTH * L + L - 1));
    check("full_s_ready", BW'(s_ready), BW'(1'b0));
    check("full_adv", BW'(n_adv - d0), BW'(OBUF_DEPTH));
    check("full_busy", BW'(busy), BW'(1'b1));

    // Release the sink while the buffer is full: sustained 1 sample/cycle.
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = DW'(200 + i);
      tick();
    end
    a0 = n_acc; o0 = n_out;
    for (int i = 0; i < 30; i++) begin
      s_data = DW'(300 + i);
      tick();
    end
    check("sustain_in", BW'(n_acc - a0), BW'(30));
    check("sustain_out", BW'(n_out - o0), BW'(30));
    for (int i = 0; i < 10 && tb_phase != 0; i++) begin
      s_valid = 1'b1;
      s_data = DW'(400 + i);
      tick();
    end
    drain();
    check("sustain_done_ready", BW'(s_ready), BW'(1'b1));

    // Random valid/ready, 300 samples.
    a0 = n_acc; o0 = n_out;
    for (int i = 0; i < 5000 && (n_acc - a0) < 300; i++) begin
      m_ready = 1'(($urandom_range(0, 1)));
      s_valid = ((n_acc - a0) < 300) ? 1'(($urandom_range(0, 1))) : 1'b0;
      s_data = DW'($urandom);
      tick();
    end
    check("rand_accepts", BW'(n_acc - a0), BW'(300));
    drain();
    check("rand_outputs", BW'(n_out - o0), BW'(300));

    // Reset with a buffered block and a partial block pending.
    m_ready = 1'b0;
    for (int i = 11; i <= 13; i++) begin
      s_valid = 1'b1; s_data = DW'(i); tick();
    end
    s_valid = 1'b0;
    repeat (3) tick();
    for (int i = 14; i <= 15; i++) begin
      s_valid = 1'b1; s_data = DW'(i); tick();
    end
    s_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("mid_rst_m_valid", BW'(m_valid), BW'(1'b0));
    check("mid_rst_busy", BW'(busy), BW'(1'b0));
    exp_q.delete();
    tb_phase = 0;
    rst_n = 1'b1;
    tick();
    m_ready = 1'b1;
    d0 = n_adv; o0 = n_out;
    for (int i = 7; i <= 9; i++) begin
      s_valid = 1'b1; s_data = DW'(i); tick();
    end
    drain();
    check("fresh_fx_x", BW'(fx_x), BW'({32'd9, 32'd8, 32'd7}));
    check("fresh_adv", BW'(n_adv - d0), BW'(1));
    check("fresh_outputs", BW'(n_out - o0), BW'(3));

`ifdef FIR_SEQ_FLUSH_EN
    // Flush a partial block of 5,6 and then flush at phase 0.
    d0 = n_adv; o0 = n_out;
    for (int i = 5; i <= 6; i++) begin
      s_valid = 1'b1; s_data = DW'(i); tick();
    end
    s_valid = 1'b0;
    flush = 1'b1;
    #1;
    check("flush_s_ready", BW'(s_ready), BW'(1'b0));
    for (int i = 0; i < 10 && n_adv == d0; i++) tick();
    flush = 1'b0;
    check("flush_fx_x", BW'(fx_x), BW'({32'd0, 32'd6, 32'd5}));
    drain();
    check("flush_outputs", BW'(n_out - o0), BW'(3));
    d0 = n_adv;
    flush = 1'b1;
    repeat (4) tick();
    flush = 1'b0;
    check("flush_idle_adv", BW'(n_adv - d0), BW'(0));
    check("flush_idle_ready", BW'(s_ready), BW'(1'b1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
